fft_frame_sequencer: RTL and testbench

Frame-level controller for the 1024-point ping-pong FFT core. It accepts a streamed input frame from the host, writes it into bank A through a host-owned RAM port (bit-reversed if enabled), then pulses the core's start. After the core finishes, it streams the result bank back out with valid/ready backpressure. It owns the RAM-port mux select and the core start/done handshake, and it detects hung transforms with a watchdog.

---
 rtl/fft_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_fft_frame_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the ping-pong FFT core: loads a frame into bank A, kicks
// the core, waits for its done edge (with a watchdog), then streams results out.
module fft_frame_sequencer #(
  parameter int N_LOG2      = 10,
  parameter int DATA_W      = 32,
  parameter bit RESULT_BANK = 1'b0,
  parameter bit BITREV_LOAD = 1'b1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              host_own,
  output logic              ram_bank,
  output logic              ram_en,
  output logic              ram_we,
  output logic [N_LOG2-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              err_timeout,
  output logic [15:0]       frame_cnt
);
  localparam int N    = 1 << N_LOG2;
  localparam int CW   = N_LOG2 + 1;
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {LOAD, START, RUN, UNLOAD} state_t;
  state_t state, state_nx;

  logic [CW-1:0]     cnt;   // sample index in LOAD, read index in UNLOAD
  logic [WD_W-1:0]   wd;
  logic              done_q;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;
  logic              inflight, inflight_last;
  logic              accept, issue, pop, done_edge, wd_expire, last_pop;
  logic [N_LOG2-1:0] cnt_rev;

  always_comb begin
    cnt_rev = '0;
    for (int b = 0; b < N_LOG2; b++) cnt_rev[b] = cnt[N_LOG2-1-b];
  end

  assign s_ready   = (state == LOAD) && !rst;
  assign accept    = s_valid && s_ready;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = fifo_data[rd_ptr];
  assign m_last    = m_valid && fifo_last[rd_ptr];
  assign pop       = m_valid && m_ready;
  assign last_pop  = pop && m_last;
  assign done_edge = fft_done && !done_q;
  assign wd_expire = (wd == WD_W'(TIMEOUT_CYC - 1));
  // Occupancy after this cycle's push/pop plus the new read must fit in 2 slots.
  assign issue     = (state == UNLOAD) && (cnt != CW'(N)) &&
                     (({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (accept && cnt == CW'(N - 1)) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (done_edge) state_nx = UNLOAD;
               else if (wd_expire) state_nx = LOAD;
      UNLOAD:  if (last_pop) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    fft_start = (state == START);
    busy      = (state != LOAD);
    host_own  = !((state == START) || (state == RUN));
    ram_bank  = (state == UNLOAD) ? RESULT_BANK : 1'b0;
    ram_en    = accept || issue;
    ram_we    = accept;
    ram_wdata = s_data;
    ram_addr  = cnt[N_LOG2-1:0];
    if (state == LOAD && BITREV_LOAD) ram_addr = cnt_rev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      cnt           <= '0;
      wd            <= '0;
      done_q        <= 1'b0;
      occ           <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err_timeout   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state         <= state_nx;
      done_q        <= fft_done;
      inflight      <= issue;
      inflight_last <= issue && (cnt == CW'(N - 1));
      occ           <= occ + {1'b0, inflight} - {1'b0, pop};
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      case (state)
        LOAD:   if (accept) cnt <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
        START:  wd <= '0;
        RUN: begin
          wd <= wd + 1'b1;
          // A done edge coinciding with expiry takes priority over the abort.
          if (wd_expire && !done_edge) err_timeout <= 1'b1;
        end
        UNLOAD: begin
          if (issue) cnt <= cnt + 1'b1;
          if (last_pop) begin
            cnt       <= '0;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) begin
      fifo_data[wr_ptr] <= ram_rdata;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench: frame scenarios from a table with a RAM and core model,
// plus bit-reverse address vectors and a mid-unload reset sequence.
module tb_fft_frame_sequencer;
  localparam int N_LOG2 = 10;
  localparam int N      = 1 << N_LOG2;
  localparam int DW     = 32;
  localparam int TMO    = 100;

  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, m_ready = 1'b0, fft_done = 1'b0;
  logic [DW-1:0] s_data = '0, ram_rdata = '0;
  logic s_ready, m_valid, m_last, fft_start, host_own, ram_bank, ram_en, ram_we;
  logic busy, err_timeout;
  logic [DW-1:0] m_data, ram_wdata;
  logic [N_LOG2-1:0] ram_addr;
  logic [15:0] frame_cnt;

  fft_frame_sequencer #(.N_LOG2(N_LOG2), .DATA_W(DW), .RESULT_BANK(1'b0),
                        .BITREV_LOAD(1'b1), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .fft_start(fft_start), .fft_done(fft_done), .host_own(host_own),
    .ram_bank(ram_bank), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Dual-bank RAM, host port, synchronous read
  logic [DW-1:0] mem [2][N];
  int own_viol = 0;
  always @(posedge clk) begin
    if (ram_en && host_own) begin
      if (ram_we) mem[ram_bank][ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_bank][ram_addr];
    end
    if (ram_en && !host_own) own_viol <= own_viol + 1;
  end

  // Core model: done rises done_delay cycles after start (0 = never)
  int done_delay = 0;
  bit keep_done = 1'b0;
  int core_cnt = 0;
  bit core_run = 1'b0;
  always @(posedge clk) begin
    if (fft_start) begin
      core_cnt <= 0;
      core_run <= 1'b1;
      if (!keep_done) fft_done <= 1'b0;
    end else if (core_run) begin
      core_cnt <= core_cnt + 1;
      if (done_delay != 0 && core_cnt + 1 == done_delay) begin
        fft_done <= 1'b1;
        core_run <= 1'b0;
      end
    end
  end

  function automatic int bitrev(input int k);
    int r = 0;
    for (int b = 0; b < N_LOG2; b++) if (k[b]) r |= 1 << (N_LOG2 - 1 - b);
    return r;
  endfunction

  function automatic logic [DW-1:0] sval(input int fid, input int k);
    return {8'(fid), 8'hA5, 16'(k)};
  endfunction

  typedef struct {
    int done_delay; bit keep_done; int ready_pct;
    int exp_beats; int exp_run; bit exp_err; int exp_frames;
  } frame_t;

  typedef struct { int k; int exp_addr; } addr_vec_t;

  int wr_addr [N];

  task automatic run_frame(input frame_t f, input int fid, input int abort_after);
    int beats = 0, cyc = 0, t_unload = -1, t_first = -1, t_last = -1, run_cyc = 0;
    int occ_m = 0, infl_m = 0, pop_p = 0, iss_p = 0;
    int load_bad = 0, data_bad = 0, last_bad = 0, stable_bad = 0, occ_bad = 0, mv_bad = 0;
    logic [DW-1:0] held = '0;
    bit stalled = 1'b0, finished = 1'b0, aborted = 1'b0;
    done_delay = f.done_delay;
    keep_done  = f.keep_done;
    m_ready    = 1'b0;
    while (!s_ready && cyc < 100) begin @(negedge clk); cyc++; end
    check("ready_before_load", s_ready, 1);
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b1;
      s_data  = sval(fid, k);
      #1;
      if (!(ram_en && ram_we && ram_bank == 1'b0 && host_own && ram_wdata == s_data)) load_bad++;
      wr_addr[k] = int'(ram_addr);
      @(negedge clk);
    end
    s_valid = 1'b0;
    #1;
    check("start_pulse", fft_start, 1);
    check("start_host_own", host_own, 0);
    @(negedge clk); #1;
    check("start_single", fft_start, 0);
    cyc = 0;
    while (!finished && cyc < 20000) begin
      m_ready = ($urandom_range(99) < f.ready_pct);
      #1;
      if (busy && !host_own && !fft_start) run_cyc++;
      if (busy && host_own && t_unload < 0) t_unload = cyc;
      occ_m  = occ_m + infl_m - pop_p;
      infl_m = iss_p;
      if (occ_m + infl_m > 2) occ_bad++;
      if (m_valid !== (occ_m != 0)) mv_bad++;
      if (stalled && m_data !== held) stable_bad++;
      if (m_valid && t_first < 0) t_first = cyc;
      if (m_valid && m_ready) begin
        if (m_data !== sval(fid, bitrev(beats))) data_bad++;
        if (m_last !== (beats == N - 1)) last_bad++;
        if (beats == N - 1) t_last = cyc;
        beats++;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      pop_p   = (m_valid && m_ready) ? 1 : 0;
      iss_p   = (ram_en && !ram_we && host_own && busy) ? 1 : 0;
      if (abort_after > 0 && beats == abort_after) begin aborted = 1'b1; break; end
      @(negedge clk);
      cyc++;
      if (!busy) finished = 1'b1;
    end
    m_ready = 1'b0;
    check("load_writes_bad", load_bad, 0);
    check("beat_data_bad", data_bad, 0);
    check("stall_stable_bad", stable_bad, 0);
    check("fifo_bound_bad", occ_bad, 0);
    check("m_valid_model_bad", mv_bad, 0);
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1; #1;
      check("rst_mid_s_ready", s_ready, 0);
      @(negedge clk);
      rst = 1'b0; #1;
      check("rst_mid_m_valid", m_valid, 0);
      check("rst_mid_host_own", host_own, 1);
      check("rst_mid_frame_cnt", frame_cnt, 0);
      check("rst_mid_busy", busy, 0);
      return;
    end
    check("frame_finished", finished, 1);
    #1;
    check("beats", beats, f.exp_beats);
    check("last_bad", last_bad, 0);
    check("run_cycles", run_cyc, f.exp_run);
    check("err_timeout", err_timeout, f.exp_err);
    check("frame_cnt", frame_cnt, f.exp_frames);
    check("s_ready_after", s_ready, 1);
    if (f.exp_beats == 0) check("no_m_valid", t_first, -1);
    if (f.ready_pct == 100 && f.exp_beats == N) begin
      check("first_valid_lat", t_first - t_unload, 2);
      check("last_beat_lat", t_last - t_unload, N + 1);
    end
  endtask

  frame_t    frames [6];
  addr_vec_t avec [8];

  initial begin
    frames[0] = '{50,  1'b0, 100, N, 51,  1'b0, 1};
    frames[1] = '{30,  1'b0, 30,  N, 31,  1'b0, 2};
    frames[2] = '{99,  1'b0, 100, N, 100, 1'b0, 3};  // done edge on the expiry cycle
    frames[3] = '{0,   1'b1, 100, 0, 100, 1'b1, 3};  // stale high done, no edge
    frames[4] = '{100, 1'b0, 100, 0, 100, 1'b1, 3};  // one cycle too late
    frames[5] = '{40,  1'b0, 70,  N, 41,  1'b1, 4};
    avec[0] = '{0, 0};     avec[1] = '{1, 512};   avec[2] = '{2, 256};
    avec[3] = '{3, 768};   avec[4] = '{5, 640};   avec[5] = '{512, 1};
    avec[6] = '{1022, 511}; avec[7] = '{1023, 1023};

    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      s_valid = 1'($urandom_range(1));
      s_data  = $urandom;
      m_ready = 1'($urandom_range(1));
    end
    #1;
    check("rst_s_ready_low", s_ready, 0);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_host_own", host_own, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(frames[i], i + 1, 0);
      if (i == 0)
        for (int v = 0; v < 8; v++) check("bitrev_addr", wr_addr[avec[v].k], avec[v].exp_addr);
    end

    run_frame('{50, 1'b0, 100, N, 51, 1'b0, 0}, 7, 501);
    run_frame('{50, 1'b0, 100, N, 51, 1'b0, 1}, 8, 0);
    check("ram_owner_viol", own_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
